// File: rtl/core_pkg.sv
// Shared constants and types for the pipelined RISC-V core front end.
package core_pkg;

  localparam int unsigned PC_W_DEF         = 8;
  localparam logic [31:0] CORE_NOP_INST    = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] CORE_EBREAK_INST = 32'h0010_0073;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: rst > clear (bubble) > hold > load.
module if_id_reg
  import core_pkg::*;
#(
  parameter int unsigned PC_W     = PC_W_DEF,
  parameter logic [31:0] NOP_INST = CORE_NOP_INST
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            clr,
  input  logic [31:0]     in_inst,
  input  logic [PC_W-1:0] in_pc,
  input  logic [PC_W-1:0] in_pcp4,
  output logic [31:0]     id_inst,
  output logic [PC_W-1:0] id_pc,
  output logic [PC_W-1:0] id_pcp4,
  output logic            id_valid
);

  logic [31:0]     inst_q,  inst_d;
  logic [PC_W-1:0] pc_q,    pc_d;
  logic [PC_W-1:0] pcp4_q,  pcp4_d;
  logic            valid_q, valid_d;

  // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    inst_d  = inst_q;
    pc_d    = pc_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    if (clr) begin
      // A bubble keeps the old PC fields; only the word and valid change.
      inst_d  = NOP_INST;
      valid_d = 1'b0;
    end else if (en) begin
      inst_d  = in_inst;
      pc_d    = in_pc;
      pcp4_d  = in_pcp4;
      valid_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_q  <= NOP_INST;
      pc_q    <= '0;
      pcp4_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
    end
  end

  assign id_inst  = inst_q;
  assign id_pc    = pc_q;
  assign id_pcp4  = pcp4_q;
  assign id_valid = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC and RUN/HALT control, feeds the IF/ID register.
module if_stage
  import core_pkg::*;
#(
  parameter int unsigned     PC_W     = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP_INST = CORE_NOP_INST
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_target,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     id_inst,
  output logic [PC_W-1:0] id_pc,
  output logic [PC_W-1:0] id_pcp4,
  output logic            id_valid,
  output logic            halted
);

  localparam logic [PC_W-1:0] PC_INC = PC_W'(4);

  logic [PC_W-1:0] pc_q, pc_d;
  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_plus4;
  logic [PC_W-1:0] target_aligned;
  logic            ifid_en;
  logic            ifid_clr;
  logic            unused_tgt_lsb;

  assign pc_plus4       = pc_q + PC_INC;
  assign target_aligned = {redirect_target[PC_W-1:2], 2'b00};
  assign unused_tgt_lsb = ^redirect_target[1:0];

  always_comb begin
    pc_d     = pc_q;
    state_d  = state_q;
    ifid_en  = 1'b0;
    ifid_clr = 1'b0;
    unique case (state_q)
      RUN: begin
        if (redirect) begin
          pc_d     = target_aligned;
          ifid_clr = 1'b1;
        end else if (!stall) begin
          ifid_en = 1'b1;
          // EBREAK still goes to decode, but the PC parks on it.
          if (imem_rdata == CORE_EBREAK_INST) state_d = HALT;
          else                                pc_d    = pc_plus4;
        end
      end
      HALT: begin
        if (redirect) begin
          state_d  = RUN;
          pc_d     = target_aligned;
          ifid_clr = 1'b1;
        end else if (!stall) begin
          ifid_clr = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      state_q <= RUN;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  if_id_reg #(
    .PC_W     (PC_W),
    .NOP_INST (NOP_INST)
  ) u_if_id_reg (
    .clk      (clk),
    .rst      (rst),
    .en       (ifid_en),
    .clr      (ifid_clr),
    .in_inst  (imem_rdata),
    .in_pc    (pc_q),
    .in_pcp4  (pc_plus4),
    .id_inst  (id_inst),
    .id_pc    (id_pc),
    .id_pcp4  (id_pcp4),
    .id_valid (id_valid)
  );

  assign imem_addr = pc_q;
  assign halted    = (state_q == HALT);

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: per-cycle expectations are queued, then compared after the edge.
module tb_if_stage;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef struct packed {
    logic [31:0] inst;
    logic [7:0]  pc;
    logic [7:0]  pcp4;
    logic        valid;
    logic [7:0]  addr;
    logic        halted;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst, stall, redirect;
  logic [7:0]  redirect_target;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] id_inst;
  logic [7:0]  id_pc, id_pcp4;
  logic        id_valid, halted;

  logic [31:0] mem [64];
  obs_t        exp_q [$];
  string       name_q [$];
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr[7:2]];

  if_stage #(.PC_W(8), .RESET_PC(8'h00), .NOP_INST(NOP)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .id_inst         (id_inst),
    .id_pc           (id_pc),
    .id_pcp4         (id_pcp4),
    .id_valid        (id_valid),
    .halted          (halted)
  );

  // addi x1,x1,k with a distinct k per word so any skip or duplicate is visible.
  function automatic logic [31:0] addi_word(input int k);
    return {12'(k), 20'h08093};
  endfunction

  // Queue what the DUT must show after the next edge, clock once, then score it.
  task automatic step(input string name, input logic [31:0] inst, input logic [7:0] pc,
                      input logic [7:0] pcp4, input logic valid, input logic [7:0] addr,
                      input logic hlt);
    obs_t e, got;
    string n;
    exp_q.push_back('{inst: inst, pc: pc, pcp4: pcp4, valid: valid, addr: addr, halted: hlt});
    name_q.push_back(name);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    n = name_q.pop_front();
    got = '{inst: id_inst, pc: id_pc, pcp4: id_pcp4, valid: id_valid, addr: imem_addr, halted: halted};
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL %s: got inst=%h pc=%h pcp4=%h valid=%b addr=%h halted=%b want inst=%h pc=%h pcp4=%h valid=%b addr=%h halted=%b",
               n, got.inst, got.pc, got.pcp4, got.valid, got.addr, got.halted,
               e.inst, e.pc, e.pcp4, e.valid, e.addr, e.halted);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b1; redirect = 1'b1; redirect_target = 8'h80;
    step("reset_a", NOP, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    stall = 1'b0; redirect = 1'b0;
    step("reset_b", NOP, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    checks++;
    if (imem_addr !== 8'h00) begin
      failures++;
      $display("FAIL reset_addr: got %h want 00", imem_addr);
    end
  endtask

  task automatic test_free_run();
    step("run0", mem[0], 8'h00, 8'h04, 1'b1, 8'h04, 1'b0);
    step("run1", mem[1], 8'h04, 8'h08, 1'b1, 8'h08, 1'b0);
  endtask

  task automatic test_stall();
    stall = 1'b1;
    step("stall0", mem[1], 8'h04, 8'h08, 1'b1, 8'h08, 1'b0);
    step("stall1", mem[1], 8'h04, 8'h08, 1'b1, 8'h08, 1'b0);
    stall = 1'b0;
    step("unstall0", mem[2], 8'h08, 8'h0C, 1'b1, 8'h0C, 1'b0);
    step("unstall1", mem[3], 8'h0C, 8'h10, 1'b1, 8'h10, 1'b0);
  endtask

  task automatic test_redirect_stall();
    stall = 1'b1; redirect = 1'b1; redirect_target = 8'h23;
    step("redir_stall", NOP, 8'h0C, 8'h10, 1'b0, 8'h20, 1'b0);
    stall = 1'b0; redirect = 1'b0;
    step("redir_after", mem[8], 8'h20, 8'h24, 1'b1, 8'h24, 1'b0);
  endtask

  task automatic test_back_to_back();
    redirect = 1'b1; redirect_target = 8'h31;
    step("b2b0", NOP, 8'h20, 8'h24, 1'b0, 8'h30, 1'b0);
    redirect_target = 8'h46;
    step("b2b1", NOP, 8'h20, 8'h24, 1'b0, 8'h44, 1'b0);
    redirect = 1'b0;
    step("b2b_after", mem[17], 8'h44, 8'h48, 1'b1, 8'h48, 1'b0);
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_target = 8'hFE;
    step("wrap_redir", NOP, 8'h44, 8'h48, 1'b0, 8'hFC, 1'b0);
    redirect = 1'b0;
    step("wrap_adv", mem[63], 8'hFC, 8'h00, 1'b1, 8'h00, 1'b0);
  endtask

  task automatic test_ebreak();
    mem[4] = EBREAK;
    redirect = 1'b1; redirect_target = 8'h0C;
    step("eb_redir", NOP, 8'hFC, 8'h00, 1'b0, 8'h0C, 1'b0);
    redirect = 1'b0;
    step("eb_pre", mem[3], 8'h0C, 8'h10, 1'b1, 8'h10, 1'b0);
    step("eb_cap", EBREAK, 8'h10, 8'h14, 1'b1, 8'h10, 1'b1);
    stall = 1'b1;
    step("eb_stall", EBREAK, 8'h10, 8'h14, 1'b1, 8'h10, 1'b1);
    stall = 1'b0;
    step("halt0", NOP, 8'h10, 8'h14, 1'b0, 8'h10, 1'b1);
    step("halt1", NOP, 8'h10, 8'h14, 1'b0, 8'h10, 1'b1);
    redirect = 1'b1; redirect_target = 8'h40;
    step("resume", NOP, 8'h10, 8'h14, 1'b0, 8'h40, 1'b0);
    redirect = 1'b0;
    step("resume_adv", mem[16], 8'h40, 8'h44, 1'b1, 8'h44, 1'b0);
  endtask

  task automatic test_reset_in_halt();
    redirect = 1'b1; redirect_target = 8'h10;
    step("rh_redir", NOP, 8'h40, 8'h44, 1'b0, 8'h10, 1'b0);
    redirect = 1'b0;
    step("rh_cap", EBREAK, 8'h10, 8'h14, 1'b1, 8'h10, 1'b1);
    rst = 1'b1; stall = 1'b1;
    step("rh_reset", NOP, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    rst = 1'b0; stall = 1'b0;
    step("rh_run", mem[0], 8'h00, 8'h04, 1'b1, 8'h04, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = addi_word(i + 1);
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = 8'h00;
    #1;
    test_reset();
    test_free_run();
    test_stall();
    test_redirect_stall();
    test_back_to_back();
    test_wrap();
    test_ebreak();
    test_reset_in_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the pipelined RISC-V core.
- Owns the PC and drives the address of the combinational instruction memory.
- Registers the returned instruction, its PC and PC+4 towards the decode stage.
- Honours stall from the hazard unit, redirect/flush from branch resolution, and stops fetching at EBREAK.

Parameters:
- PC_W, 8, PC and instruction-memory address width in bits.
- RESET_PC, 0, PC value loaded on reset.
- NOP_INST, 32'h0000_0013, instruction word presented on id_inst for a bubble (addi x0,x0,0).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- stall  in  1  hold PC and IF/ID contents this cycle
- redirect  in  1  taken branch/jump: load new PC, squash the instruction in IF/ID
- redirect_target  in  PC_W  new PC; bits [1:0] forced to 0
- imem_addr  out  PC_W  current PC, to instruction memory (combinational read)
- imem_rdata  in  32  instruction word at imem_addr, same cycle
- id_inst  out  32  registered instruction for decode
- id_pc  out  PC_W  registered PC of id_inst
- id_pcp4  out  PC_W  registered id_pc + 4, modulo 2^PC_W
- id_valid  out  1  id_inst is a real instruction (0 = bubble)
- halted  out  1  fetch stopped after EBREAK

Behaviour:
- Reset is synchronous and active-high on clk/rst and overrides everything.
  - Reset values: PC = RESET_PC; id_inst = NOP_INST; id_pc = 0; id_pcp4 = 0; id_valid = 0; halted = 0; state = RUN.
- imem_addr = PC, combinational from the PC register.
- Latency: the word fetched at PC in cycle N appears on id_* in cycle N+1 with id_valid = 1.
- State machine with two states, RUN and HALT.
- RUN, per-cycle priority is rst > redirect > stall > advance:
  - redirect = 1: PC <= {redirect_target[PC_W-1:2], 2'b00}; IF/ID <= bubble (id_inst = NOP_INST, id_valid = 0, id_pc/id_pcp4 unchanged). Redirect wins even when stall = 1.
  - stall = 1, no redirect: PC and all id_* hold their values.
  - advance: IF/ID <= {imem_rdata, PC, PC+4, valid = 1}; PC <= PC+4, wrapping modulo 2^PC_W.
  - On advance, if imem_rdata == 32'h0010_0073 (EBREAK): EBREAK is still loaded into IF/ID with valid = 1, PC holds at the EBREAK address, and the next state is HALT.
- HALT:
  - halted = 1 in every cycle spent in HALT (registered; it rises the cycle after EBREAK is captured).
  - PC holds. If stall = 0, IF/ID <= bubble; if stall = 1, IF/ID holds so that EBREAK is not lost while decode is stalled.
  - redirect = 1: go to RUN, halted <= 0, PC loaded and IF/ID bubbled exactly as in RUN.
  - rst: go to RUN with the reset values.
- Boundary conditions:
  - PC wrap: 0xFC + 4 = 0x00. id_pcp4 wraps the same way.
  - A misaligned redirect_target is silently aligned; no error output.
  - Reset asserted mid-stall or mid-redirect: reset values next cycle, no partial update.
  - Back-to-back redirects: each cycle loads the latest target and keeps id_valid = 0.
  - No instruction is ever duplicated or dropped across a stall.

Decomposition:
- Shared package (core_pkg): PC_W default, the NOP_INST and EBREAK_INST constants, and an enum fetch_state_t {RUN, HALT}.
- Optional sub-module if_id_reg: the IF/ID pipeline register with enable (= !stall) and synchronous clear (bubble). Its load/hold/clear priority is rst > clear > hold > load; if_stage asserts clear for redirect and for a non-stalled HALT cycle. PC and FSM stay in if_stage.

Test Plan:
- Reset then free-run, with memory holding addi words at 0x00, 0x04, 0x08 → imem_addr = 0x00, 0x04, 0x08 on successive cycles; id_valid 0,1,1; id_pc = 0x00 then 0x04; id_pcp4 = 0x04 then 0x08.
- stall = 1 for 2 cycles while PC = 0x08 → imem_addr stays 0x08; id_inst/id_pc (0x04) frozen; after release id_pc = 0x08. No skip, no duplicate.
- redirect = 1 with target 0x23 while stall = 1 → next cycle PC = 0x20, id_valid = 0, id_inst = 0x0000_0013; following cycle id_pc = 0x20, id_valid = 1.
- PC = 0xFC, advance → id_pc = 0xFC, id_pcp4 = 0x00, imem_addr = 0x00.
- EBREAK at 0x10 → id_inst = 0x0010_0073 with id_valid = 1, then halted = 1. imem_addr holds 0x10; id_valid = 0 thereafter. A redirect to 0x40 resumes fetch with halted = 0.
- rst asserted one cycle during HALT with stall = 1 → next cycle PC = RESET_PC, halted = 0, id_valid = 0.
